// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: alternate / walk / bounce / hold modes stepped every TOP+1 clocks.
// Optional `LED_PWM_EN adds a brightness input and a registered PWM gate on the LED outputs.
module led_pattern_seq #(
    parameter int LED_WIDTH       = 4,
    parameter int CLOCK_FREQ_HZ   = 10000000,
    parameter int PULSE_FREQ_MULT = 12,
    parameter int PULSE_FREQ_DVSR = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [LED_WIDTH-1:0] pattern,
`ifdef LED_PWM_EN
    input  logic [2:0]           brightness,
`endif
    output logic [LED_WIDTH-1:0] led,
    output logic                 step
);

    localparam int TOP = (CLOCK_FREQ_HZ * PULSE_FREQ_DVSR / 2) / PULSE_FREQ_MULT;
    localparam int CW  = $clog2(TOP + 1);
    localparam logic [CW-1:0] TOP_C = CW'(TOP);

    localparam logic [1:0] M_ALT    = 2'b00;
    localparam logic [1:0] M_WALK   = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;
    localparam logic [1:0] M_HOLD   = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [LED_WIDTH-1:0] ONE_HOT0 = LED_WIDTH'(1);

    logic [CW-1:0]        counter, counter_n;
    logic [LED_WIDTH-1:0] led_state, led_n;
    logic                 step_q, step_n;
    logic                 dir, dir_n;
    logic [1:0]           cur_mode, mode_n;
    logic                 reload, reload_n;

    logic [LED_WIDTH-1:0] shl, shr, rotl;
    logic                 load;

    assign shl  = led_state << 1;
    assign shr  = led_state >> 1;
    // Written as two shifts so it also degenerates correctly to identity at LED_WIDTH=1.
    assign rotl = (led_state << 1) | (led_state >> (LED_WIDTH - 1));
    assign load = reload || (mode != cur_mode);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            led_state <= '0;
            step_q    <= 1'b0;
            dir       <= DIR_UP;
            cur_mode  <= M_ALT;
            reload    <= 1'b1;
        end else begin
            counter   <= counter_n;
            led_state <= led_n;
            step_q    <= step_n;
            dir       <= dir_n;
            cur_mode  <= mode_n;
            reload    <= reload_n;
        end
    end

    // Next-state logic
    always_comb begin
        counter_n = counter;
        led_n     = led_state;
        step_n    = 1'b0;
        dir_n     = dir;
        mode_n    = cur_mode;
        reload_n  = reload;
        if (load) begin
            // A load always wins, even over a step falling due on the same edge.
            counter_n = '0;
            mode_n    = mode;
            reload_n  = 1'b0;
            dir_n     = DIR_UP;
            case (mode)
                M_WALK, M_BOUNCE: led_n = ONE_HOT0;
                default:          led_n = pattern;
            endcase
        end else if (enable) begin
            if (counter != TOP_C) begin
                counter_n = counter + 1'b1;
            end else begin
                counter_n = '0;
                step_n    = 1'b1;
                case (cur_mode)
                    M_ALT:  led_n = ~led_state;
                    M_WALK: led_n = rotl;
                    M_BOUNCE: begin
                        if (LED_WIDTH == 1) begin
                            led_n = led_state;
                        end else if (dir == DIR_UP) begin
                            led_n = shl;
                            if (shl[LED_WIDTH-1]) dir_n = DIR_DOWN;
                        end else begin
                            led_n = shr;
                            if (shr[0]) dir_n = DIR_UP;
                        end
                    end
                    default: led_n = pattern;
                endcase
            end
            if (cur_mode == M_HOLD) led_n = pattern;
        end
    end

    // Outputs
    assign step = step_q;

`ifdef LED_PWM_EN
    logic [2:0]           pwm_cnt;
    logic [LED_WIDTH-1:0] led_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
            led_q   <= led_state & {LED_WIDTH{pwm_cnt <= brightness}};
        end
    end

    assign led = led_q;
`else
    assign led = led_state;
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with TOP=50 (step period 51 clocks), LED_WIDTH=4.
module tb_led_pattern_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   mode;
    logic [W-1:0] pattern;
    logic [W-1:0] led;
    logic         step;
`ifdef LED_PWM_EN
    logic [2:0]   brightness;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    led_pattern_seq #(
        .LED_WIDTH(W), .CLOCK_FREQ_HZ(100), .PULSE_FREQ_MULT(1), .PULSE_FREQ_DVSR(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .pattern(pattern),
`ifdef LED_PWM_EN
        .brightness(brightness),
`endif
        .led(led), .step(step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until step is seen (bounded); n = number of edges taken.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (step !== 1'b1 && n < 200);
    endtask

    task automatic test_reset();
        int n;
        logic [W-1:0] exp_seq [4] = '{4'h5, 4'hA, 4'h5, 4'hA};
        reset = 1'b1; enable = 1'b1; mode = 2'b00; pattern = 4'hA;
        tick(); tick();
        n_checks++;
        if (led !== 4'h0 || step !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: led=%h step=%b, want led=0 step=0", led, step);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (led !== 4'hA || step !== 1'b0) begin
            n_fail++; $display("FAIL reset_load: led=%h step=%b, want led=a step=0", led, step);
        end
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            n_checks++;
            if (n !== 51 || led !== exp_seq[i]) begin
                n_fail++; $display("FAIL alt_step%0d: period=%0d led=%h, want period=51 led=%h", i, n, led, exp_seq[i]);
            end
        end
        tick();
        n_checks++;
        if (step !== 1'b0) begin
            n_fail++; $display("FAIL step_width: step=%b one cycle after pulse, want 0", step);
        end
    endtask

    task automatic test_walk();
        int n;
        logic [W-1:0] exp_seq [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
        mode = 2'b01;
        tick();
        n_checks++;
        if (led !== 4'h1 || step !== 1'b0) begin
            n_fail++; $display("FAIL walk_load: led=%h step=%b, want led=1 step=0", led, step);
        end
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            n_checks++;
            if (n !== 51 || led !== exp_seq[i]) begin
                n_fail++; $display("FAIL walk_step%0d: period=%0d led=%h, want period=51 led=%h", i, n, led, exp_seq[i]);
            end
        end
    endtask

    task automatic test_bounce();
        int n;
        logic [W-1:0] exp_seq [7] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        mode = 2'b10;
        tick();
        n_checks++;
        if (led !== 4'h1) begin
            n_fail++; $display("FAIL bounce_load: led=%h, want 1", led);
        end
        for (int i = 0; i < 7; i++) begin
            wait_step(n);
            n_checks++;
            if (n !== 51 || led !== exp_seq[i]) begin
                n_fail++; $display("FAIL bounce_step%0d: period=%0d led=%h, want period=51 led=%h", i, n, led, exp_seq[i]);
            end
        end
    endtask

    task automatic test_freeze();
        int n;
        logic bad = 1'b0;
        mode = 2'b00; pattern = 4'hA;
        tick();
        for (int i = 0; i < 20; i++) tick();
        // Pattern change mid-run must not affect alternate until the next load.
        pattern = 4'h3;
        enable = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (led !== 4'hA || step !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL freeze_hold: led=%h step=%b while disabled, want led=a step=0", led, step);
        end
        enable = 1'b1;
        wait_step(n);
        n_checks++;
        if (n !== 31 || led !== 4'h5) begin
            n_fail++; $display("FAIL freeze_resume: period=%0d led=%h, want period=31 led=5", n, led);
        end
    endtask

    task automatic test_collision();
        int n;
        pattern = 4'hA;
        mode = 2'b01;
        tick();
        for (int i = 0; i < 50; i++) tick();
        mode = 2'b00;
        tick();
        n_checks++;
        if (step !== 1'b0 || led !== 4'hA) begin
            n_fail++; $display("FAIL collision_load: step=%b led=%h, want step=0 led=a", step, led);
        end
        wait_step(n);
        n_checks++;
        if (n !== 51 || led !== 4'h5) begin
            n_fail++; $display("FAIL collision_restart: period=%0d led=%h, want period=51 led=5", n, led);
        end
        // Mode change while disabled still loads.
        enable = 1'b0; mode = 2'b01;
        tick();
        n_checks++;
        if (led !== 4'h1) begin
            n_fail++; $display("FAIL disabled_load: led=%h, want 1", led);
        end
        enable = 1'b1; mode = 2'b00;
        tick();
    endtask

    task automatic test_midreset();
        int n;
        for (int i = 0; i < 17; i++) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (led !== 4'h0 || step !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: led=%h step=%b, want led=0 step=0", led, step);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (led !== 4'hA) begin
            n_fail++; $display("FAIL midreset_reload: led=%h, want a", led);
        end
        wait_step(n);
        n_checks++;
        if (n !== 51 || led !== 4'h5) begin
            n_fail++; $display("FAIL midreset_step: period=%0d led=%h, want period=51 led=5", n, led);
        end
    endtask

    task automatic test_hold();
        int n;
        mode = 2'b11; pattern = 4'h3;
        tick();
        n_checks++;
        if (led !== 4'h3) begin
            n_fail++; $display("FAIL hold_load: led=%h, want 3", led);
        end
        pattern = 4'hC;
        tick();
        n_checks++;
        if (led !== 4'hC) begin
            n_fail++; $display("FAIL hold_track: led=%h, want c", led);
        end
        enable = 1'b0; pattern = 4'h6;
        tick();
        n_checks++;
        if (led !== 4'hC) begin
            n_fail++; $display("FAIL hold_frozen: led=%h, want c", led);
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if (led !== 4'h6) begin
            n_fail++; $display("FAIL hold_resume: led=%h, want 6", led);
        end
        wait_step(n);
        n_checks++;
        if (n !== 49 || led !== 4'h6) begin
            n_fail++; $display("FAIL hold_step: period=%0d led=%h, want period=49 led=6", n, led);
        end
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        int on_cnt;
        logic bad;
        mode = 2'b11; pattern = 4'hF; brightness = 3'd3;
        for (int i = 0; i < 4; i++) tick();
        on_cnt = 0; bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led === 4'hF) on_cnt++;
            else if (led !== 4'h0) bad = 1'b1;
        end
        n_checks++;
        if (on_cnt !== 8 || bad) begin
            n_fail++; $display("FAIL pwm_duty3: on=%0d of 16 partial=%b, want on=8", on_cnt, bad);
        end
        brightness = 3'd7;
        tick(); tick();
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led === 4'hF) on_cnt++;
        end
        n_checks++;
        if (on_cnt !== 16) begin
            n_fail++; $display("FAIL pwm_duty7: on=%0d of 16, want 16", on_cnt);
        end
    endtask
`endif

    initial begin
`ifdef LED_PWM_EN
        brightness = 3'd7;
`endif
        test_reset();
        test_walk();
        test_bounce();
        test_freeze();
        test_collision();
        test_midreset();
        test_hold();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
